uart_data_receive: RTL and testbench

- UART receiver. Deserialises 8N1 frames on `rx` into bytes: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Counterpart to the UART transmitter, with the same bit timing: one bit lasts countOfStrobe+1 clocks. Loopback of transmitter `tx` to `rx` must be lossless.
- Feeds the odometry/command parser with a byte and a one-cycle valid strobe. Flags framing errors.

---
 rtl/uart_data_receive.sv | 162 ++++++++++++++++
 tb/tb_uart_data_receive.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_data_receive.sv
// uart_data_receive
//   8N1 UART receiver: one start bit, eight data bits LSB first, one stop bit.
//   A bit lasts countOfStrobe+1 clocks. The start bit is confirmed at its
//   centre, and from that point each later bit is sampled one bit period
//   after the previous one.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   rx         asynchronous serial line, idle high
//   data       last correctly received byte, held until the next good frame
//   data_rdy   one-clock pulse: data was just updated
//   frame_err  one-clock pulse: stop bit sampled low, frame discarded
//   busy       high while a frame is in progress (START/DATA/STOP)
//
// state | meaning
// HUNT  | wait for the line to be seen high before accepting a start bit
// IDLE  | line high, waiting for a falling edge
// START | timing to the centre of the start bit to confirm it
// DATA  | sampling the eight data bits at their centres
// STOP  | sampling the stop bit at its centre
module uart_data_receive #(
    parameter int countOfStrobe = 865
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_rdy,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW   = $clog2(countOfStrobe + 1);
    localparam int HALF = countOfStrobe / 2;

    localparam logic [CW-1:0] TERM_C = CW'(countOfStrobe);
    localparam logic [CW-1:0] HALF_C = CW'(HALF);
    // HUNT needs three consecutive high samples of rx_s. The two sync flops
    // come out of reset high, so a shorter qualifier would let a line that is
    // held low through reset look idle for two clocks.
    localparam logic [CW-1:0] HUNT_C = CW'(2);

    typedef enum logic [2:0] {
        HUNT,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shreg, shreg_nx;
    logic [7:0]    data_nx;
    logic          rdy_nx, err_nx;
    logic          rx_meta, rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= HUNT;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            data_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= bit_idx_nx;
            shreg     <= shreg_nx;
            data      <= data_nx;
            data_rdy  <= rdy_nx;
            frame_err <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        data_nx    = data;
        rdy_nx     = 1'b0;
        err_nx     = 1'b0;
        case (state)
            HUNT: begin
                if (!rx_s) begin
                    cnt_nx = '0;
                end else if (cnt == HUNT_C) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (!rx_s) begin
                    cnt_nx   = '0;
                    state_nx = START;
                end
            end
            START: begin
                if (cnt == HALF_C) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        state_nx = IDLE;
                    end else begin
                        bit_idx_nx = '0;
                        state_nx   = DATA;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == TERM_C) begin
                    cnt_nx     = '0;
                    shreg_nx   = {rx_s, shreg[7:1]};
                    bit_idx_nx = bit_idx + 1'b1;
                    if (bit_idx == 4'd7) begin
                        state_nx = STOP;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == TERM_C) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        data_nx  = shreg;
                        rdy_nx   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        // Line still low at the stop bit: treat as a break and
                        // insist on seeing it high again before the next frame.
                        err_nx   = 1'b1;
                        state_nx = HUNT;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = HUNT;
            end
        endcase
    end

    always_comb begin
        busy = (state == START) || (state == DATA) || (state == STOP);
    end

endmodule

// File: tb/tb_uart_data_receive.sv
module tb_uart_data_receive;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx0, rx1, rx2;
    logic [7:0] data0, data1, data2;
    logic       rdy0, rdy1, rdy2;
    logic       err0, err1, err2;
    logic       busy0, busy1, busy2;

    int checks = 0;
    int fails  = 0;

    // Expected strobes per lane: {is_frame_err, byte}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [7:0] last_good[3];
    logic       rst_prev = 1'b0;

    always #50 clk = ~clk;

    uart_data_receive #(.countOfStrobe(14)) u0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .data(data0),
        .data_rdy(rdy0), .frame_err(err0), .busy(busy0));
    uart_data_receive #(.countOfStrobe(15)) u1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .data(data1),
        .data_rdy(rdy1), .frame_err(err1), .busy(busy1));
    uart_data_receive #(.countOfStrobe(16)) u2 (
        .clk(clk), .rst_n(rst_n), .rx(rx2), .data(data2),
        .data_rdy(rdy2), .frame_err(err2), .busy(busy2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 20)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input int lane, input logic err, input logic [7:0] b);
        case (lane)
            0:       q0.push_back({err, b});
            1:       q1.push_back({err, b});
            default: q2.push_back({err, b});
        endcase
    endfunction

    function automatic int q_size(input int lane);
        case (lane)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [8:0] pop_exp(input int lane);
        case (lane)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic check_lane(input int lane, input logic rdy, input logic err, input logic [7:0] d);
        logic [8:0] e;
        if (rdy || err) begin
            if (q_size(lane) == 0) begin
                check($sformatf("unexpected strobe lane%0d", lane), {30'd0, rdy, err}, 32'd0);
            end else begin
                e = pop_exp(lane);
                check($sformatf("strobe kind lane%0d", lane), {30'd0, rdy, err},
                      e[8] ? 32'd1 : 32'd2);
                if (!e[8]) last_good[lane] = e[7:0];
            end
        end
        check($sformatf("data lane%0d", lane), {24'd0, d}, {24'd0, last_good[lane]});
    endtask

    // Monitor: reset seen at the previous posedge clears the model's byte.
    always @(negedge clk) begin
        if (!rst_prev) begin
            for (int i = 0; i < 3; i++) last_good[i] = 8'h00;
        end
        check_lane(0, rdy0, err0, data0);
        check_lane(1, rdy1, err1, data1);
        check_lane(2, rdy2, err2, data2);
        rst_prev = rst_n;
    end

    task automatic set_rx(input int lane, input logic v);
        case (lane)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Called at a posedge; holds the bit for p clocks and returns at a posedge.
    task automatic drive_bit(input int lane, input logic v, input int p);
        #1 set_rx(lane, v);
        repeat (p) @(posedge clk);
    endtask

    task automatic send_frame(input int lane, input logic [7:0] b, input logic stop, input int p);
        push_exp(lane, !stop, stop ? b : 8'h00);
        drive_bit(lane, 1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(lane, b[i], p);
        drive_bit(lane, stop, p);
    endtask

    // Lane 1 transmitter with a bit time that is not a whole number of clocks.
    task automatic send_timed(input logic [7:0] b, input int bit_t);
        push_exp(1, 1'b0, b);
        rx1 = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx1 = b[i];
            #(bit_t);
        end
        rx1 = 1'b1;
        #(bit_t);
    endtask

    initial begin
        #(200000 * 100);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] partial;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset data", {24'd0, data1}, 32'h00);
        check("reset data_rdy", {31'd0, rdy1}, 32'd0);
        check("reset frame_err", {31'd0, err1}, 32'd0);
        check("reset busy", {31'd0, busy1}, 32'd0);
        repeat (20) @(posedge clk);

        // Single frame with busy window
        fork
            send_frame(1, 8'hA5, 1'b1, 16);
            begin
                repeat (4) @(negedge clk);
                check("busy after start", {31'd0, busy1}, 32'd1);
                repeat (140) @(negedge clk);
                check("busy mid frame", {31'd0, busy1}, 32'd1);
            end
        join
        @(negedge clk);
        check("busy after frame", {31'd0, busy1}, 32'd0);
        @(posedge clk);

        // Back-to-back frames
        send_frame(1, 8'h00, 1'b1, 16);
        send_frame(1, 8'hFF, 1'b1, 16);
        send_frame(1, 8'h3C, 1'b1, 16);
        repeat (32) @(posedge clk);

        // Glitch shorter than half a bit
        #1 rx1 = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx1 = 1'b1;
        @(negedge clk);
        check("busy during glitch", {31'd0, busy1}, 32'd1);
        repeat (10) @(negedge clk);
        check("busy after glitch", {31'd0, busy1}, 32'd0);
        @(posedge clk);
        repeat (32) @(posedge clk);
        send_frame(1, 8'h5A, 1'b1, 16);
        repeat (32) @(posedge clk);

        // Framing error followed by a held-low line
        send_frame(1, 8'h11, 1'b1, 16);
        send_frame(1, 8'h3C, 1'b0, 16);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("busy while line held low", {31'd0, busy1}, 32'd0);
        @(posedge clk);
        drive_bit(1, 1'b1, 32);
        send_frame(1, 8'h7E, 1'b1, 16);
        repeat (32) @(posedge clk);

        // Reset during data bit 4 with the line held low afterwards
        partial = 8'hC3;
        drive_bit(1, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(1, partial[i], 16);
        #1 rx1 = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("busy after mid-frame reset", {31'd0, busy1}, 32'd0);
        check("data after mid-frame reset", {24'd0, data1}, 32'h00);
        repeat (80) @(negedge clk);
        check("busy with line low after reset", {31'd0, busy1}, 32'd0);
        @(posedge clk);
        drive_bit(1, 1'b1, 32);
        send_frame(1, 8'hC3, 1'b1, 16);
        repeat (32) @(posedge clk);

        // Random loopback at three bit rates, plus +/-3% rate error on lane 1
        fork
            for (int i = 0; i < 256; i++) send_frame(0, 8'($urandom), 1'b1, 15);
            for (int i = 0; i < 256; i++) send_frame(2, 8'($urandom), 1'b1, 17);
            begin
                for (int i = 0; i < 128; i++) send_frame(1, 8'($urandom), 1'b1, 16);
                for (int i = 0; i < 64; i++) send_timed(8'($urandom), 1648);
                for (int i = 0; i < 64; i++) send_timed(8'($urandom), 1552);
            end
        join
        @(posedge clk);
        repeat (60) @(posedge clk);

        check("pending lane0", q_size(0), 32'd0);
        check("pending lane1", q_size(1), 32'd0);
        check("pending lane2", q_size(2), 32'd0);
        check("idle busy lane0", {31'd0, busy0}, 32'd0);
        check("idle busy lane2", {31'd0, busy2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
